// File: rtl/bus_target.sv
// bus_target: valid/ready bus responder with byte-lane word RAM, GPIO latch and machine timer.
// One ready pulse per access; RAM contents survive reset.
module bus_target #(
  parameter int          RAM_WORDS   = 4096,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic [3:0]  lane,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_LIM = 32'(RAM_WORDS) << 2;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_RECOVER} state_t;
  state_t r_state;
  logic r_wr, r_ram, r_io;
  logic [7:0] r_off;
  logic [3:0] r_cnt;
  logic [31:0] r_ram_q;
  logic [31:0] r_mem [RAM_WORDS];
  logic [63:0] r_mtime, r_mtimecmp;
  logic w_start, w_ram, w_io;
  logic [AW-1:0] w_idx;
  logic [31:0] w_io_rd;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction
  assign w_start = !rst && r_state == S_IDLE && valid;
  assign w_ram = addr < RAM_LIM;
  assign w_io = !w_ram && addr[31:28] == IO_BASE[31:28];
  assign w_idx = addr[AW+1:2];
  assign w_io_rd = r_off == 8'h00 ? {24'd0, gpio_out} :
                   r_off == 8'h04 ? r_mtime[31:0] :
                   r_off == 8'h08 ? r_mtime[63:32] :
                   r_off == 8'h0C ? r_mtimecmp[31:0] :
                   r_off == 8'h10 ? r_mtimecmp[63:32] :
                   r_off == 8'h14 ? 32'h5256_3332 : 32'd0;
  always_ff @(posedge clk)
    if (w_start && w_ram) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (lane[i]) r_mem[w_idx][8*i +: 8] <= din[8*i +: 8];
      end else r_ram_q <= r_mem[w_idx];
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      ready <= 1'b0;
      dout <= 32'd0;
      gpio_out <= 8'd0;
      r_mtime <= 64'd0;
      r_mtimecmp <= '1;
      timer_irq <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      timer_irq <= r_mtime >= r_mtimecmp;
      r_mtime <= r_mtime + 64'd1;
      case (r_state)
        S_IDLE: if (valid) begin
          r_wr <= wr;
          r_ram <= w_ram;
          r_io <= w_io;
          r_off <= addr[7:0];
          r_cnt <= 4'(WAIT_STATES);
          r_state <= S_ACCESS;
          // a write to either mtime half suppresses that cycle's increment
          if (wr && w_io)
            case (addr[7:0])
              8'h00: gpio_out <= lane[0] ? din[7:0] : gpio_out;
              8'h04: r_mtime <= {r_mtime[63:32], merge(r_mtime[31:0], din, lane)};
              8'h08: r_mtime <= {merge(r_mtime[63:32], din, lane), r_mtime[31:0]};
              8'h0C: r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], din, lane);
              8'h10: r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], din, lane);
              default: ;
            endcase
        end
        S_ACCESS: if (r_cnt == 4'd0) begin
          dout <= r_wr ? 32'd0 : r_ram ? r_ram_q : r_io ? w_io_rd : 32'd0;
          ready <= 1'b1;
          r_state <= S_RESP;
        end else r_cnt <= r_cnt - 4'd1;
        S_RESP: begin
          ready <= 1'b0;
          r_state <= S_RECOVER;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: directed scoreboard bench driving a zero-wait and a three-wait instance.
module tb_bus_target;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, din = 0;
  logic wr = 0, v0 = 0, v3 = 0;
  logic [3:0] lane = 0;
  logic [31:0] dout0, dout3;
  logic ready0, ready3, irq0, irq3;
  logic [7:0] gpio0, gpio3;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  bus_target #(.RAM_WORDS(4096), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout0), .wr(wr), .lane(lane),
    .valid(v0), .ready(ready0), .gpio_out(gpio0), .timer_irq(irq0));
  bus_target #(.RAM_WORDS(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout3), .wr(wr), .lane(lane),
    .valid(v3), .ready(ready3), .gpio_out(gpio3), .timer_irq(irq3));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input bit s3, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] l, input string tag);
    int lat = 0;
    logic got = 0;
    logic [31:0] e;
    addr = a; din = d; wr = w; lane = l;
    if (s3) v3 = 1; else v0 = 1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (s3 ? ready3 : ready0) begin
        got = 1;
        lat = i;
        break;
      end
      addr = $urandom; din = $urandom; wr = 1'($urandom_range(0, 1)); lane = 4'($urandom_range(0, 15));
    end
    e = exp_q.pop_front();
    chk({tag, " timeout"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, " latency"}, 64'(lat), s3 ? 64'd5 : 64'd2);
      chk({tag, " dout"}, 64'(s3 ? dout3 : dout0), 64'(e));
    end
    @(posedge clk); #1;
    chk({tag, " single pulse"}, 64'(s3 ? ready3 : ready0), 64'd0);
    v0 = 0; v3 = 0;
    @(posedge clk); #1;
  endtask
  task automatic do_rd(input bit s3, input logic [31:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    xfer(s3, 1'b0, a, 32'd0, 4'd0, tag);
  endtask
  task automatic do_wr(input bit s3, input logic [31:0] a, input logic [31:0] d, input logic [3:0] l, input string tag);
    exp_q.push_back(32'd0);
    xfer(s3, 1'b1, a, d, l, tag);
  endtask
  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 64'(ready0), 64'd0);
    chk("rst dout", 64'(dout0), 64'd0);
    chk("rst gpio", 64'(gpio0), 64'd0);
    chk("rst irq", 64'(irq0), 64'd0);
    chk("rst ready3", 64'(ready3), 64'd0);
    rst = 0;
    do_rd(0, 32'h8000_000C, 32'hFFFF_FFFF, "cmp lo reset");
    do_wr(0, 32'h10, 32'h1234_5678, 4'hF, "wr 0x10");
    do_rd(0, 32'h10, 32'h1234_5678, "rd 0x10");
    do_wr(0, 32'h14, 32'h1122_3344, 4'hF, "wr 0x14");
    do_wr(0, 32'h16, 32'hAABB_CCDD, 4'b0100, "wr lane2");
    do_rd(0, 32'h14, 32'h11BB_3344, "rd lane2");
    do_wr(0, 32'h14, 32'hDEAD_BEEF, 4'b0000, "wr no lanes");
    do_rd(0, 32'h14, 32'h11BB_3344, "rd no lanes");
    do_wr(1, 32'h8, 32'h55AA_55AA, 4'hF, "ws3 wr");
    do_rd(1, 32'h8, 32'h55AA_55AA, "ws3 rd");
    do_rd(1, 32'h8000_0014, 32'h5256_3332, "ws3 id");
    do_wr(0, 32'h8000_0010, 32'd0, 4'hF, "cmp hi");
    do_wr(0, 32'h8000_000C, 32'd100, 4'hF, "cmp lo");
    do_wr(0, 32'h8000_0008, 32'd0, 4'hF, "mtime hi");
    do_wr(0, 32'h8000_0004, 32'd90, 4'hF, "mtime lo");
    chk("irq after load", 64'(irq0), 64'd0);
    repeat (7) begin @(posedge clk); #1; end
    chk("irq at 99", 64'(irq0), 64'd0);
    @(posedge clk); #1;
    chk("irq at 100", 64'(irq0), 64'd1);
    do_wr(0, 32'h8000_000C, 32'hFFFF_FFFF, 4'hF, "cmp lo max");
    chk("irq dropped", 64'(irq0), 64'd0);
    do_wr(0, 32'h8000_0008, 32'd0, 4'hF, "carry hi");
    do_wr(0, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, "carry lo");
    do_rd(0, 32'h8000_0008, 32'd1, "carry rd hi");
    do_rd(0, 32'h8000_0004, 32'd7, "carry rd lo");
    do_wr(0, 32'h8000_0000, 32'h0000_00A5, 4'hF, "gpio wr");
    chk("gpio out", 64'(gpio0), 64'hA5);
    do_rd(0, 32'h8000_0000, 32'hA5, "gpio rd");
    do_rd(0, 32'h8000_0014, 32'h5256_3332, "id rd");
    do_rd(0, 32'h8000_0018, 32'd0, "io hole");
    do_wr(0, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, "unmapped wr");
    do_rd(0, 32'h4000_0000, 32'd0, "unmapped rd");
    do_wr(0, 32'h20, 32'hCAFE_F00D, 4'hF, "pre-reset wr");
    addr = 32'h8; wr = 0; lane = 0; v3 = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1; v3 = 0;
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready3) seen = 1;
    end
    chk("abort no ready", 64'(seen), 64'd0);
    chk("abort gpio", 64'(gpio0), 64'd0);
    chk("abort gpio3", 64'(gpio3), 64'd0);
    do_rd(0, 32'h20, 32'hCAFE_F00D, "ram kept");
    do_rd(1, 32'h8, 32'h55AA_55AA, "ws3 after abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
